trdb_retire_serializer: RTL and testbench

TRDB_RETIRE_SERIALIZER -- requirements
Module: trdb_retire_serializer

---
 rtl/trdb_pkg.sv | 22 ++
 rtl/trdb_retire_compact.sv | 26 ++
 rtl/trdb_retire_serializer.sv | 134 +++++++++++++
 tb/tb_trdb_retire_serializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trdb_pkg.sv
// Shared types for the trace-debugger retirement path: the single-instruction
// record exchanged between the core retirement lanes, the serializer FIFO and
// the encoder.
package trdb_pkg;

    localparam int CAUSELEN = 5;
    localparam int XLEN     = 32;
    localparam int PRIVLEN  = 2;
    localparam int ILEN     = 32;

    typedef struct packed {
        logic                iexception;
        logic                interrupt;
        logic [CAUSELEN-1:0] cause;
        logic [XLEN-1:0]     tval;
        logic [PRIVLEN-1:0]  priv;
        logic [XLEN-1:0]     iaddr;
        logic [ILEN-1:0]     instr;
        logic                compressed;
    } trdb_instr_t;

endpackage

// File: rtl/trdb_retire_compact.sv
// Lane compaction: for each retirement lane, the dense slot offset it lands on
// when invalid lanes are squeezed out, plus the number of valid lanes.
module trdb_retire_compact #(
    parameter int NRET = 2
) (
    input  logic [NRET-1:0]                       lane_valid_i,
    output logic [NRET-1:0][$clog2(NRET+1)-1:0]   lane_off_o,
    output logic [$clog2(NRET+1)-1:0]             count_o
);

    localparam int CW = $clog2(NRET+1);

    logic [CW-1:0] acc;

    // Running prefix count: each lane's offset is the number of valid lanes below it.
    always_comb begin
        acc        = '0;
        lane_off_o = '0;
        for (int i = 0; i < NRET; i++) begin
            lane_off_o[i] = acc;
            acc           = acc + CW'(lane_valid_i[i]);
        end
        count_o = acc;
    end

endmodule

// File: rtl/trdb_retire_serializer.sv
// Retirement serializer: accepts up to NRET retired instructions per cycle,
// buffers them in a DEPTH-entry FIFO and hands them to the encoder one per
// cycle. The core is never stalled; beats that do not fit are dropped whole
// and flagged on the sticky overflow_o.
// Optional feature: define TRDB_DROP_CNT_EN to add drop_cnt_o, a saturating
// count of dropped instructions.
//
// Handshake: the input side has no backpressure; a beat is taken when
// in_ready_o is high, otherwise it is dropped. The output side is strict
// valid/ready: a record transfers on a rising edge where out_valid_o and
// out_ready_i are both high; while out_valid_o is high and out_ready_i is
// low, out_instr_o is held stable.
module trdb_retire_serializer
    import trdb_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [NRET-1:0]              lane_valid_i,
    input  trdb_instr_t [NRET-1:0]       lane_instr_i,
    output logic                         in_ready_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output trdb_instr_t                  out_instr_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
    output logic                         overflow_o
`ifdef TRDB_DROP_CNT_EN
    ,
    output logic [15:0]                  drop_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);
    localparam int CW = $clog2(NRET+1);

    trdb_instr_t              mem_q [DEPTH];
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]            occ_q, occ_d;
    logic                     ovf_q, ovf_d;
    logic [NRET-1:0][CW-1:0]  lane_off;
    logic [CW-1:0]            lane_cnt;
    logic                     any_valid;
    logic                     push;
    logic                     pop;
    logic                     drop;

    trdb_retire_compact #(.NRET(NRET)) u_compact (
        .lane_valid_i (lane_valid_i),
        .lane_off_o   (lane_off),
        .count_o      (lane_cnt)
    );

    // Admission is judged on current occupancy only, so a same-cycle pop
    // never lengthens the combinational path from out_ready_i to in_ready_o.
    assign any_valid   = |lane_valid_i;
    assign in_ready_o  = (OW'(DEPTH) - occ_q) >= OW'(NRET);
    assign push        = in_ready_o && any_valid;
    assign drop        = !in_ready_o && any_valid;
    assign out_valid_o = (occ_q != '0);
    assign pop         = out_valid_o && out_ready_i;
    assign occupancy_o = occ_q;
    assign overflow_o  = ovf_q;
    assign out_instr_o = out_valid_o ? mem_q[rd_ptr_q] : '0;

    // Next-state for pointers, occupancy and overflow; flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        ovf_d    = ovf_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(lane_cnt);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            occ_d = occ_q + (push ? OW'(lane_cnt) : OW'(0)) - (pop ? OW'(1) : OW'(0));
            if (drop) ovf_d = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage write: valid lanes land densely from wr_ptr_q, wrapping modulo DEPTH.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            for (int i = 0; i < NRET; i++) begin
                if (lane_valid_i[i]) mem_q[wr_ptr_q + AW'(lane_off[i])] <= lane_instr_i[i];
            end
        end
    end

`ifdef TRDB_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum;

    // Dropped-instruction counter next state, saturating at all-ones.
    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + 17'(lane_cnt);
        drop_cnt_d = drop_cnt_q;
        if (flush_i)   drop_cnt_d = '0;
        else if (drop) drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Dropped-instruction counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_trdb_retire_serializer.sv
// Directed bench for trdb_retire_serializer (NRET=2, DEPTH=8).
// Define TRDB_DROP_CNT_EN to also exercise drop_cnt_o.
module tb_trdb_retire_serializer;
    import trdb_pkg::*;

    localparam int NRET  = 2;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [NRET-1:0]   lane_valid;
    trdb_instr_t [NRET-1:0] lane_instr;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    trdb_instr_t       out_instr;
    logic [3:0]        occ;
    logic              overflow;
`ifdef TRDB_DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    trdb_retire_serializer #(.NRET(NRET), .DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .lane_valid_i (lane_valid),
        .lane_instr_i (lane_instr),
        .in_ready_o   (in_ready),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_instr_o  (out_instr),
        .occupancy_o  (occ),
        .overflow_o   (overflow)
`ifdef TRDB_DROP_CNT_EN
        ,
        .drop_cnt_o   (drop_cnt)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Record derived from an address so every field is checked on pop.
    function automatic trdb_instr_t mk(input logic [31:0] a);
        trdb_instr_t r;
        r.iexception = a[2];
        r.interrupt  = a[3];
        r.cause      = a[8:4];
        r.tval       = ~a;
        r.priv       = a[9:8];
        r.iaddr      = a;
        r.instr      = a * 32'd3 + 32'd1;
        r.compressed = a[4];
        return r;
    endfunction

    // Advance one cycle; sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
        lane_valid    = v;
        lane_instr[0] = mk(a0);
        lane_instr[1] = mk(a1);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(2'b00, 32'h0, 32'h0);
        #1;
        checks++; if (occ !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occ); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
        checks++; if (out_instr !== '0) begin errors++; $display("FAIL reset_instr got %h want 0", out_instr); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef TRDB_DROP_CNT_EN
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_lane();
        drive(2'b01, 32'h1C000080, 32'h0);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_fallthrough got %b want 0", out_valid); end
        step();
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
        checks++; if (out_instr !== mk(32'h1C000080)) begin errors++; $display("FAIL single_iaddr got %h want 1c000080", out_instr.iaddr); end
        checks++; if (occ !== 4'd1) begin errors++; $display("FAIL single_occ got %0d want 1", occ); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (occ !== 4'd0) begin errors++; $display("FAIL single_drain_occ got %0d want 0", occ); end
    endtask

    task automatic test_two_lanes();
        drive(2'b11, 32'h100, 32'h104);
        out_ready = 1'b1;
        step();
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (out_instr !== mk(32'h100)) begin errors++; $display("FAIL two_first got %h want 100", out_instr.iaddr); end
        checks++; if (occ !== 4'd2) begin errors++; $display("FAIL two_occ got %0d want 2", occ); end
        step();
        checks++; if (out_valid !== 1'b1 || out_instr !== mk(32'h104)) begin errors++; $display("FAIL two_second got %h valid %b want 104", out_instr.iaddr, out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL two_empty got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_skip_lane0();
        drive(2'b10, 32'hDEAD0000, 32'h200);
        step();
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (occ !== 4'd1) begin errors++; $display("FAIL skip_occ got %0d want 1", occ); end
        checks++; if (out_instr !== mk(32'h200)) begin errors++; $display("FAIL skip_iaddr got %h want 200", out_instr.iaddr); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (occ !== 4'd0) begin errors++; $display("FAIL skip_drain got %0d want 0", occ); end
    endtask

    task automatic test_fill_overflow();
        for (int k = 0; k < 4; k++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready beat %0d got %b want 1", k, in_ready); end
            drive(2'b11, 32'h300 + 32'(8*k), 32'h304 + 32'(8*k));
            step();
        end
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (occ !== 4'd8) begin errors++; $display("FAIL fill_occ got %0d want 8", occ); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b want 0", in_ready); end
        step();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL idle_beat_ovf got %b want 0", overflow); end
        drive(2'b11, 32'h400, 32'h404);
        step();
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (occ !== 4'd8) begin errors++; $display("FAIL drop_occ got %0d want 8", occ); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drop_ovf got %b want 1", overflow); end
        checks++; if (out_instr !== mk(32'h300)) begin errors++; $display("FAIL hold_stable got %h want 300", out_instr.iaddr); end
`ifdef TRDB_DROP_CNT_EN
        checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL drop_cnt got %0d want 2", drop_cnt); end
`endif
        exp_q = '{32'h300, 32'h304, 32'h308};
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_instr !== mk(exp_q[0])) begin errors++; $display("FAIL fill_order got %h want %h", out_instr.iaddr, exp_q[0]); end
            void'(exp_q.pop_front());
            step();
        end
        out_ready = 1'b0;
        checks++; if (occ !== 4'd5) begin errors++; $display("FAIL partial_drain_occ got %0d want 5", occ); end
    endtask

    task automatic test_flush();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL preflush_ovf got %b want 1", overflow); end
        flush = 1'b1;
        out_ready = 1'b1;
        drive(2'b11, 32'h500, 32'h504);
        step();
        flush = 1'b0;
        out_ready = 1'b0;
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (occ !== 4'd0) begin errors++; $display("FAIL flush_occ got %0d want 0", occ); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf got %b want 0", overflow); end
`ifdef TRDB_DROP_CNT_EN
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL flush_drop got %0d want 0", drop_cnt); end
`endif
    endtask

    task automatic test_wrap();
        drive(2'b01, 32'h600, 32'h0);
        step();
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (out_instr !== mk(32'h600)) begin errors++; $display("FAIL wrap_prime got %h want 600", out_instr.iaddr); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 32'h700 + 32'(8*k), 32'h704 + 32'(8*k));
            exp_q.push_back(32'h700 + 32'(8*k));
            exp_q.push_back(32'h704 + 32'(8*k));
            step();
        end
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (occ !== 4'd6) begin errors++; $display("FAIL wrap_occ6 got %0d want 6", occ); end
        drive(2'b11, 32'h740, 32'h744);
        exp_q.push_back(32'h740);
        exp_q.push_back(32'h744);
        out_ready = 1'b1;
        checks++; if (out_instr !== mk(exp_q[0])) begin errors++; $display("FAIL wrap_head got %h want %h", out_instr.iaddr, exp_q[0]); end
        void'(exp_q.pop_front());
        step();
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (occ !== 4'd7) begin errors++; $display("FAIL wrap_occ7 got %0d want 7", occ); end
        for (int k = 0; k < 7; k++) begin
            checks++; if (out_valid !== 1'b1 || out_instr !== mk(exp_q[0])) begin errors++; $display("FAIL wrap_order got %h valid %b want %h", out_instr.iaddr, out_valid, exp_q[0]); end
            void'(exp_q.pop_front());
            step();
        end
        out_ready = 1'b0;
        checks++; if (occ !== 4'd0) begin errors++; $display("FAIL wrap_drained got %0d want 0", occ); end
    endtask

    task automatic test_reset_mid_op();
        drive(2'b11, 32'h800, 32'h804);
        step();
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (occ !== 4'd2) begin errors++; $display("FAIL midrst_pre got %0d want 2", occ); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (occ !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_occ got %0d valid %b want 0 0", occ, out_valid); end
        checks++; if (out_instr !== '0) begin errors++; $display("FAIL midrst_instr got %h want 0", out_instr); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_two_lanes();
        test_skip_lane0();
        test_fill_overflow();
        test_flush();
        test_wrap();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
